// File: rtl/muldiv_seq_if.sv
// Execute-stage <-> multiply/divide sequencer handshake: one M-op in, one tagged result out.
interface muldiv_seq_if #(
    parameter int XLEN = 64
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [4:0]      rd_in;
    logic            flush;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output start, funct3, rs1, rs2, rd_in, flush,
        input  busy, stall, done, result, rd_out
    );

    modport slave (
        input  start, funct3, rs1, rs2, rd_in, flush,
        output busy, stall, done, result, rd_out
    );
endinterface

// File: rtl/muldiv_seq.sv
// RV64M multi-cycle sequencer: radix-2 shift-add multiply / restoring divide on magnitudes,
// sign fix-up in a final cycle, and a one-cycle fast path for divide-by-zero and overflow.
module muldiv_seq #(
    parameter int XLEN = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    muldiv_seq_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_FAST} state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic              busy_q;
    logic              done_q;
    logic [XLEN-1:0]   result_q;
    logic [4:0]        rd_out_q;
    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic              sign1_q;
    logic              sign2_q;
    logic              dz_q;
    logic [XLEN-1:0]   opnd_q;
    logic [2*XLEN-1:0] acc_q;

    logic              s1_d;
    logic              s2_d;
    logic              is_dz;
    logic              is_ovf;
    logic [XLEN-1:0]   mag1;
    logic [XLEN-1:0]   mag2;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_hi;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] mul_acc_d;
    logic [2*XLEN-1:0] div_acc_d;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_result;
    logic [XLEN-1:0]   fast_result;
    logic              last_iter;

    always_comb begin
        s1_d   = bus.rs1[XLEN-1] & ((bus.funct3 == 3'b001) | (bus.funct3 == 3'b010) |
                                    (bus.funct3 == 3'b100) | (bus.funct3 == 3'b110));
        s2_d   = bus.rs2[XLEN-1] & ((bus.funct3 == 3'b001) | (bus.funct3 == 3'b100) |
                                    (bus.funct3 == 3'b110));
        mag1   = s1_d ? ((~bus.rs1) + XLEN'(1)) : bus.rs1;
        mag2   = s2_d ? ((~bus.rs2) + XLEN'(1)) : bus.rs2;
        is_dz  = bus.funct3[2] & (bus.rs2 == '0);
        is_ovf = bus.funct3[2] & ~bus.funct3[0] & (bus.rs1 == INT_MIN) & (bus.rs2 == '1);

        // Multiply: acc = {partial product, remaining multiplier bits}; carry lands in the shift.
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_acc_d = {mul_sum, acc_q[XLEN-1:1]};

        // Divide: acc = {partial remainder, dividend/quotient}; remainder < divisor keeps div_hi in XLEN+1 bits.
        div_hi    = acc_q[2*XLEN-1:XLEN-1];
        div_diff  = div_hi - {1'b0, opnd_q};
        div_acc_d = div_diff[XLEN] ? {div_hi[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

        prod_fix = (sign1_q ^ sign2_q) ? ((~acc_q) + (2*XLEN)'(1)) : acc_q;
        quot_fix = (sign1_q ^ sign2_q) ? ((~acc_q[XLEN-1:0]) + XLEN'(1)) : acc_q[XLEN-1:0];
        rem_fix  = sign1_q ? ((~acc_q[2*XLEN-1:XLEN]) + XLEN'(1)) : acc_q[2*XLEN-1:XLEN];

        case (op_q)
            3'b000:                 fix_result = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_result = quot_fix;
            default:                fix_result = rem_fix;
        endcase

        // Fast path keeps raw rs1 in acc_q low half so REM-by-zero can return it unchanged.
        if (op_q[1]) begin
            fast_result = dz_q ? acc_q[XLEN-1:0] : '0;
        end else begin
            fast_result = dz_q ? '1 : INT_MIN;
        end

        last_iter = (cnt_q == CW'(XLEN - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            dz_q     <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.flush) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start) begin
                            op_q    <= bus.funct3;
                            rd_q    <= bus.rd_in;
                            sign1_q <= s1_d;
                            sign2_q <= s2_d;
                            dz_q    <= is_dz;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            if (is_dz | is_ovf) begin
                                state_q <= S_FAST;
                                acc_q   <= {{XLEN{1'b0}}, bus.rs1};
                            end else if (bus.funct3[2]) begin
                                state_q <= S_DIV;
                                opnd_q  <= mag2;
                                acc_q   <= {{XLEN{1'b0}}, mag1};
                            end else begin
                                state_q <= S_MUL;
                                opnd_q  <= mag1;
                                acc_q   <= {{XLEN{1'b0}}, mag2};
                            end
                        end
                    end
                    S_MUL: begin
                        acc_q <= mul_acc_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (last_iter) state_q <= S_FIX;
                    end
                    S_DIV: begin
                        acc_q <= div_acc_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (last_iter) state_q <= S_FIX;
                    end
                    S_FIX: begin
                        result_q <= fix_result;
                        rd_out_q <= rd_q;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                    S_FAST: begin
                        result_q <= fast_result;
                        rd_out_q <= rd_q;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.rd_out = rd_out_q;
    assign bus.stall  = (bus.start & ~busy_q & ~bus.flush) | busy_q;
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle sequencer for the RV64M multiply/divide unit of `pipelined_datapath`. It accepts one M-extension operation from the execute stage and stalls the pipeline while running a radix-2 shift-add multiply or restoring divide over XLEN iterations. It then returns a sign-corrected 64-bit result with the destination register tag for writeback. Divide-by-zero and signed-overflow cases are resolved on a one-cycle fast path.

## Interface
- `XLEN`, 64, operand/result width; the iteration count equals XLEN.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `start`  in  1  execute stage holds a valid M-op; sampled only when `busy`=0.
- `funct3`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1`, `rs2`  in  XLEN  operands, forwarded values.
- `rd_in`  in  5  destination register.
- `flush`  in  1  pipeline flush; aborts any op in flight.
- `busy`  out  1  an op is in flight.
- `stall`  out  1  freeze IF/ID/EX: `(start & ~busy & ~flush) | busy`, combinational.
- `done`  out  1  one-cycle pulse; `result`/`rd_out` valid.
- `result`  out  XLEN  final value; held until next `done`.
- `rd_out`  out  5  latched `rd_in`.

## Operation
- FSM states: IDLE, MUL, DIV, FIX, FAST.
- IDLE + `start` + no `flush`:
  - Latch `funct3` and `rd_in`.
  - Compute operand signs: rs1 is signed for MULH, MULHSU, DIV, REM; rs2 is signed for MULH, DIV, REM.
  - Store operand magnitudes.
  - Clear the counter. Go to MUL (funct3[2]=0) or DIV (funct3[2]=1).
  - Exception: DIV/REM/DIVU/REMU with rs2==0, or DIV/REM with rs1=INT_MIN and rs2=-1, go to FAST instead.
- MUL: each cycle, if multiplier LSB=1, add the multiplicand into the upper half of a 2·XLEN accumulator. Then shift the accumulator/multiplier right. After XLEN cycles, go to FIX.
- DIV: restoring division, one quotient bit per cycle, on magnitudes. After XLEN cycles, go to FIX.
- FIX:
  - Negate the 2·XLEN product when sign1^sign2 (signed operands only).
  - Negate the quotient when sign1^sign2.
  - Negate the remainder when sign1 (remainder takes the dividend's sign).
  - Select result: MUL = low XLEN bits; MULH/MULHSU/MULHU = high XLEN bits; DIV/DIVU = quotient; REM/REMU = remainder.
  - Register `result` and `rd_out`, pulse `done`, go to IDLE.
- FAST:
  - Divide by zero: quotient = all ones; remainder = rs1.
  - Overflow: quotient = INT_MIN; remainder = 0.
  - Register `result`, pulse `done`, go to IDLE.
- `start` while `busy`=1 is ignored; the stalled pipeline holds it.
- `flush` in any state: go to IDLE at the next edge; no `done`; `result` keeps its old value.
- `flush` and `start` in the same IDLE cycle: the op is not accepted.

## Timing
- Reset (asynchronous, `reset`=0): state=IDLE, counter=0, `busy`=0, `done`=0, `result`=0, `rd_out`=0.
- `start` sampled at edge E0 (IDLE):
  - `busy`=1 from E0.
  - Iterations run at E1..E_XLEN.
  - FIX occupies the cycle after E_XLEN.
  - `result`/`done` are registered at E_(XLEN+1); `busy`=0 at the same edge.
  - Latency: 65 edges for XLEN=64.
- Fast path: `result`/`done` registered at E1.
- `done` lasts exactly one cycle, while `busy`=0 and `stall`=0, so EX/MEM captures `result` on the next edge.
- A new `start` is legal in the `done` cycle and is accepted at that edge (back-to-back ops).
- `reset` asserted mid-operation: immediate return to reset values; no `done` pulse after release.

## Test plan
- MUL: rs1=15, rs2=-3 → `done` exactly 65 edges after start, `result`=-45, `rd_out`=4; `stall` high throughout, low in the `done` cycle.
- MULH(15,-3) → -1; MULHSU(-3,200) → -1; MULHU(15,200) → 0; MUL(INT_MIN,-1) → INT_MIN.
- Divide: DIV(15,-3) → -5; DIVU(200,15) → 13; DIV(-3,15) → 0; REM(15,-3) → 0; REMU(200,15) → 5; REM(-3,15) → -3; REMU(15,200) → 15.
- Fast path, `done` at E1:
  - DIV(7,0) → all ones; REM(7,0) → 7; DIVU(7,0) → all ones.
  - DIV(INT_MIN,-1) → INT_MIN; REM(INT_MIN,-1) → 0.
- Back-to-back and ignored start: second `start` issued in the `done` cycle → accepted, `done` 65 edges later. `start` with different operands mid-operation → ignored; the first result is unchanged.
- Abort: `flush` at iteration 30 → IDLE next edge, no `done`, `result` unchanged. `reset`=0 at iteration 40 → all outputs 0 immediately, no later `done`.
